// File: rtl/trap_commit_ctrl.sv
// trap_commit_ctrl: commit/trap sequencer between the execute and fetch stages.
//   Accepts one executed instruction (i_valid/o_ready). In the following EXEC cycle
//   it drives the CSR file's write/trap controls for exactly one cycle. It then
//   offers the next PC to fetch (o_npc_valid/i_npc_ready). o_retired pulses in the
//   cycle after each next-PC handshake.
// Ports:
//   i_clock, i_reset (async, active-low)
//   execute side : i_valid, o_ready, i_pc, i_dnpc, i_jump, i_kind, i_csr_addr, i_csr_wdata
//   CSR side     : o_csr_wen, o_csr_t, o_csr, o_csr_pc, o_csr_wdata, o_mcause, i_csr_upc
//   fetch side   : o_npc_valid, i_npc_ready, o_npc, o_retired
// Optional build macro: MISALIGN_TRAP_EN. When it is defined, a taken jump to a
// target that is not word-aligned is converted to a trap with mcause 0.
module trap_commit_ctrl #(
  parameter logic [31:0] ECALL_CAUSE = 32'd11,
  parameter logic [31:0] RESET_PC    = 32'h8000_0000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_dnpc,
  input  logic        i_jump,
  input  logic [1:0]  i_kind,
  input  logic [11:0] i_csr_addr,
  input  logic [31:0] i_csr_wdata,
  output logic        o_csr_wen,
  output logic [2:0]  o_csr_t,
  output logic [11:0] o_csr,
  output logic [31:0] o_csr_pc,
  output logic [31:0] o_csr_wdata,
  output logic [31:0] o_mcause,
  input  logic [31:0] i_csr_upc,
  output logic        o_npc_valid,
  input  logic        i_npc_ready,
  output logic [31:0] o_npc,
  output logic        o_retired
);

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] KIND_NORMAL = 2'b00;
  localparam logic [1:0] KIND_CSRW   = 2'b01;
  localparam logic [1:0] KIND_ECALL  = 2'b10;
  localparam logic [1:0] KIND_MRET   = 2'b11;

  localparam logic [2:0] CSR_T_MRET  = 3'b000;
  localparam logic [2:0] CSR_T_CSRW  = 3'b001;
  localparam logic [2:0] CSR_T_ECALL = 3'b011;
  localparam logic [2:0] CSR_T_NONE  = 3'b111;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t          state;
  logic [XLEN-1:0] lat_dnpc;
  logic            lat_jump;
  logic [1:0]      lat_kind;

  // Accept-time decode of the incoming instruction into CSR controls
  logic [2:0]      acc_csr_t;
  logic            acc_wen;
  logic [XLEN-1:0] acc_mcause;
  // EXEC-time next-PC selection from latched fields and the CSR target
  logic [XLEN-1:0] npc_sel;
  logic            lat_misalign;

  // Ready depends on state only, so there is no path from i_valid to o_ready
  assign o_ready = (state == IDLE);

`ifdef MISALIGN_TRAP_EN
  logic acc_misalign;
  assign acc_misalign = (i_kind == KIND_NORMAL) && i_jump && (i_dnpc[1:0] != 2'b00);
  assign lat_misalign = (lat_kind == KIND_NORMAL) && lat_jump && (lat_dnpc[1:0] != 2'b00);
`else
  logic acc_misalign;
  assign acc_misalign = 1'b0;
  assign lat_misalign = 1'b0;
`endif

  // Decode the CSR op presented during EXEC
  always_comb begin
    acc_csr_t  = CSR_T_NONE;
    acc_wen    = 1'b0;
    acc_mcause = '0;
    case (i_kind)
      KIND_NORMAL: begin
        if (acc_misalign) begin
          acc_csr_t = CSR_T_ECALL;
          acc_wen   = 1'b1;
        end
      end
      KIND_CSRW: begin
        acc_csr_t = CSR_T_CSRW;
        acc_wen   = 1'b1;
      end
      KIND_ECALL: begin
        acc_csr_t  = CSR_T_ECALL;
        acc_wen    = 1'b1;
        acc_mcause = ECALL_CAUSE;
      end
      KIND_MRET: acc_csr_t = CSR_T_MRET;
      default: acc_csr_t = CSR_T_NONE;
    endcase
  end

  // Next PC; pc+4 wraps naturally in 32 bits
  always_comb begin
    npc_sel = o_csr_pc + XLEN'(4);
    case (lat_kind)
      KIND_NORMAL: begin
        if (lat_misalign)  npc_sel = i_csr_upc;
        else if (lat_jump) npc_sel = lat_dnpc;
      end
      KIND_CSRW:  npc_sel = o_csr_pc + XLEN'(4);
      KIND_ECALL: npc_sel = i_csr_upc;
      KIND_MRET:  npc_sel = i_csr_upc;
      default:    npc_sel = o_csr_pc + XLEN'(4);
    endcase
  end

  // Sequencer: CSR controls are loaded on accept so they are live for the EXEC cycle only
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state       <= IDLE;
      lat_dnpc    <= '0;
      lat_jump    <= 1'b0;
      lat_kind    <= KIND_NORMAL;
      o_csr       <= '0;
      o_csr_pc    <= '0;
      o_csr_wdata <= '0;
      o_csr_t     <= CSR_T_NONE;
      o_csr_wen   <= 1'b0;
      o_mcause    <= '0;
      o_npc       <= RESET_PC;
      o_npc_valid <= 1'b0;
      o_retired   <= 1'b0;
    end else begin
      o_retired <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid) begin
            lat_dnpc    <= i_dnpc;
            lat_jump    <= i_jump;
            lat_kind    <= i_kind;
            o_csr       <= i_csr_addr;
            o_csr_pc    <= i_pc;
            o_csr_wdata <= i_csr_wdata;
            o_csr_t     <= acc_csr_t;
            o_csr_wen   <= acc_wen;
            o_mcause    <= acc_mcause;
            state       <= EXEC;
          end
        end
        EXEC: begin
          o_npc       <= npc_sel;
          o_npc_valid <= 1'b1;
          o_csr_t     <= CSR_T_NONE;
          o_csr_wen   <= 1'b0;
          o_mcause    <= '0;
          state       <= RESP;
        end
        RESP: begin
          if (i_npc_ready) begin
            o_npc_valid <= 1'b0;
            o_retired   <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_commit_ctrl.sv
module tb_trap_commit_ctrl;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_pc;
  logic [31:0] i_dnpc;
  logic        i_jump;
  logic [1:0]  i_kind;
  logic [11:0] i_csr_addr;
  logic [31:0] i_csr_wdata;
  logic        o_csr_wen;
  logic [2:0]  o_csr_t;
  logic [11:0] o_csr;
  logic [31:0] o_csr_pc;
  logic [31:0] o_csr_wdata;
  logic [31:0] o_mcause;
  logic [31:0] i_csr_upc;
  logic        o_npc_valid;
  logic        i_npc_ready;
  logic [31:0] o_npc;
  logic        o_retired;

  trap_commit_ctrl dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_pc(i_pc), .i_dnpc(i_dnpc), .i_jump(i_jump), .i_kind(i_kind),
    .i_csr_addr(i_csr_addr), .i_csr_wdata(i_csr_wdata), .o_csr_wen(o_csr_wen),
    .o_csr_t(o_csr_t), .o_csr(o_csr), .o_csr_pc(o_csr_pc), .o_csr_wdata(o_csr_wdata),
    .o_mcause(o_mcause), .i_csr_upc(i_csr_upc), .o_npc_valid(o_npc_valid),
    .i_npc_ready(i_npc_ready), .o_npc(o_npc), .o_retired(o_retired)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] pc;
    logic [31:0] dnpc;
    logic        jump;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] upc;
    int          stall;
    logic [31:0] exp_npc;
    logic [2:0]  exp_t;
    logic        exp_wen;
    logic [31:0] exp_mcause;
  } vec_t;

  vec_t vecs[8];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    int   cyc;
    logic [31:0] held;
    @(negedge i_clock);
    i_kind = v.kind; i_pc = v.pc; i_dnpc = v.dnpc; i_jump = v.jump;
    i_csr_addr = v.addr; i_csr_wdata = v.wdata; i_csr_upc = v.upc;
    i_npc_ready = 1'b0; i_valid = 1'b1;
    chk("ready_idle", 32'(o_ready), 32'd1);
    sb.push_back(v);
    @(posedge i_clock); #1;
    i_valid = 1'b0;
    // EXEC cycle
    chk("retired_low", 32'(o_retired), 32'd0);
    chk("ready_exec", 32'(o_ready), 32'd0);
    chk("csr_t", 32'(o_csr_t), 32'(v.exp_t));
    chk("csr_wen", 32'(o_csr_wen), 32'(v.exp_wen));
    chk("mcause", o_mcause, v.exp_mcause);
    chk("csr_pc", o_csr_pc, v.pc);
    chk("npc_valid_exec", 32'(o_npc_valid), 32'd0);
    if (v.kind == 2'b01) begin
      chk("csr_addr", 32'(o_csr), 32'(v.addr));
      chk("csr_wdata", o_csr_wdata, v.wdata);
    end
    cyc = 0;
    while (!o_npc_valid && cyc < 8) begin
      @(posedge i_clock); #1;
      cyc++;
    end
    if (!o_npc_valid) begin
      n_vec++; n_err++;
      $display("FAIL npc_valid_timeout: got 0 expected 1");
    end
    e = sb.pop_front();
    chk("npc", o_npc, e.exp_npc);
    chk("latency", 32'(cyc), 32'd1);
    chk("csr_t_resp", 32'(o_csr_t), 32'd7);
    chk("wen_resp", 32'(o_csr_wen), 32'd0);
    chk("mcause_resp", o_mcause, 32'd0);
    held = e.exp_npc;
    for (int s = 0; s < e.stall; s++) begin
      @(posedge i_clock); #1;
      chk("npc_stable", o_npc, held);
      chk("npc_valid_stall", 32'(o_npc_valid), 32'd1);
      chk("ready_stall", 32'(o_ready), 32'd0);
      chk("retired_stall", 32'(o_retired), 32'd0);
    end
    @(negedge i_clock);
    i_npc_ready = 1'b1;
    @(posedge i_clock); #1;
    i_npc_ready = 1'b0;
    chk("retired_pulse", 32'(o_retired), 32'd1);
    chk("npc_valid_done", 32'(o_npc_valid), 32'd0);
    chk("ready_done", 32'(o_ready), 32'd1);
  endtask

  initial begin
    // kind, pc, dnpc, jump, addr, wdata, upc, stall, exp_npc, exp_t, exp_wen, exp_mcause
    vecs[0] = '{2'b00, 32'h8000_0010, 32'h0, 1'b0, 12'h0, 32'h0, 32'h0, 0,
                32'h8000_0014, 3'b111, 1'b0, 32'd0};
    vecs[1] = '{2'b01, 32'h8000_0030, 32'h0, 1'b0, 12'h305, 32'h8000_1000, 32'h0, 1,
                32'h8000_0034, 3'b001, 1'b1, 32'd0};
    vecs[2] = '{2'b10, 32'h8000_0020, 32'h0, 1'b0, 12'h0, 32'h0, 32'h8000_1000, 0,
                32'h8000_1000, 3'b011, 1'b1, 32'd11};
    vecs[3] = '{2'b11, 32'h8000_0040, 32'h0, 1'b0, 12'h0, 32'h0, 32'h8000_0024, 5,
                32'h8000_0024, 3'b000, 1'b0, 32'd0};
    vecs[4] = '{2'b00, 32'h8000_0050, 32'h8000_0200, 1'b1, 12'h0, 32'h0, 32'h1234_5678, 2,
                32'h8000_0200, 3'b111, 1'b0, 32'd0};
    vecs[5] = '{2'b00, 32'hFFFF_FFFC, 32'h0, 1'b0, 12'h0, 32'h0, 32'h0, 0,
                32'h0000_0000, 3'b111, 1'b0, 32'd0};
    vecs[6] = '{2'b01, 32'hFFFF_FFFC, 32'h8000_0300, 1'b1, 12'h341, 32'hDEAD_BEEF, 32'h0, 0,
                32'h0000_0000, 3'b001, 1'b1, 32'd0};
`ifdef MISALIGN_TRAP_EN
    vecs[7] = '{2'b00, 32'h8000_0060, 32'h8000_0102, 1'b1, 12'h0, 32'h0, 32'h8000_1000, 0,
                32'h8000_1000, 3'b011, 1'b1, 32'd0};
`else
    vecs[7] = '{2'b00, 32'h8000_0060, 32'h8000_0102, 1'b1, 12'h0, 32'h0, 32'h8000_1000, 0,
                32'h8000_0102, 3'b111, 1'b0, 32'd0};
`endif

    i_reset = 1'b0; i_valid = 1'b0; i_pc = '0; i_dnpc = '0; i_jump = 1'b0;
    i_kind = 2'b00; i_csr_addr = '0; i_csr_wdata = '0; i_csr_upc = '0; i_npc_ready = 1'b0;
    repeat (2) @(posedge i_clock);
    @(negedge i_clock);
    i_reset = 1'b1;
    @(posedge i_clock); #1;
    chk("rst_npc", o_npc, 32'h8000_0000);
    chk("rst_npc_valid", 32'(o_npc_valid), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_csr_t", 32'(o_csr_t), 32'd7);
    chk("rst_wen", 32'(o_csr_wen), 32'd0);
    chk("rst_retired", 32'(o_retired), 32'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset asserted during the EXEC cycle of a csrw
    @(negedge i_clock);
    i_kind = 2'b01; i_pc = 32'h8000_0070; i_csr_addr = 12'h305; i_csr_wdata = 32'h5555_AAAA;
    i_valid = 1'b1;
    @(posedge i_clock); #1;
    i_valid = 1'b0;
    chk("mid_wen_before", 32'(o_csr_wen), 32'd1);
    #1 i_reset = 1'b0;
    #1;
    chk("mid_wen_drop", 32'(o_csr_wen), 32'd0);
    chk("mid_csr_t", 32'(o_csr_t), 32'd7);
    chk("mid_ready", 32'(o_ready), 32'd1);
    chk("mid_npc", o_npc, 32'h8000_0000);
    @(posedge i_clock); #1;
    chk("mid_wen_edge", 32'(o_csr_wen), 32'd0);
    chk("mid_npc_valid", 32'(o_npc_valid), 32'd0);
    @(negedge i_clock);
    i_reset = 1'b1;
    @(posedge i_clock); #1;
    chk("post_rst_wen", 32'(o_csr_wen), 32'd0);
    chk("post_rst_npc_valid", 32'(o_npc_valid), 32'd0);
    chk("post_rst_ready", 32'(o_ready), 32'd1);

    // Machine still usable after the aborted instruction
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
